lcd_slot_loader: RTL
====================

Name: lcd_slot_loader

Overview:
- Sits directly upstream of the LCD driver on the DE2 top level.
- Produces the twelve 8-bit display bytes (line 0 positions 0-5, line 1 positions 0-5) that the LCD driver consumes.
- A debounced push-button press captures the switch byte into the next display slot. The write pointer wraps after slot 11, so the LCD shows a rolling log of entered values.

Parameters:
- DEBOUNCE_CYCLES, 1000000, number of consecutive stable iCLK cycles (20 ms at 50 MHz) needed to accept a new button level; minimum 2.
- SLOT_W, 8, width of each display slot in bits.

Ports:
- iCLK  input  1  system clock (CLOCK_50).
- iRST_N  input  1  reset: asynchronous, active-low.
- iKEY_N  input  1  raw push-button; active-low, asynchronous to iCLK, bouncing.
- iDATA  input  SLOT_W  byte to capture (switches); sampled on the press-accept cycle.
- oD0X0..oD0X5  output  SLOT_W each  line-0 slots 0-5.
- oD1X0..oD1X5  output  SLOT_W each  line-1 slots 6-11.
- oPTR  output  4  index of the next slot to be written, range 0-11.
- oWR_STB  output  1  one-cycle pulse in the cycle after a slot is written.

Behaviour:
- Reset (iRST_N low, asynchronous):
  - all twelve slots = 0
  - oPTR = 0
  - oWR_STB = 0
  - debounce stable level = 1 (released)
  - debounce counter = 0
  - both synchronizer flops = 1
- Synchronizer: 2-flop chain on iKEY_N. Its output is key_s.
- Debounce counter:
  - Clears whenever key_s equals the stable level.
  - Otherwise increments by 1 per cycle.
  - When it reaches DEBOUNCE_CYCLES-1 while key_s still differs, the stable level takes key_s and the counter clears on that same edge.
- Press event: single-cycle pulse, asserted on the cycle the stable level changes 1 -> 0. Releases (0 -> 1) produce no event.
- Write on a press event, all on the same iCLK edge:
  - slot[oPTR] <= iDATA
  - oPTR <= (oPTR == 11) ? 0 : oPTR + 1
  - oWR_STB <= 1 on that edge, back to 0 on the next edge.
- Latency: a clean low level on iKEY_N updates the slot DEBOUNCE_CYCLES + 2 cycles after the first sampling edge (2 synchronizer cycles plus the debounce count).
- Boundary conditions:
  - Holding the key: exactly one write per press.
  - Glitch or bounce shorter than DEBOUNCE_CYCLES: no write; the counter restarts on every bounce.
  - Wrap: a write at oPTR = 11 lands in oD1X5, then oPTR becomes 0. The next press overwrites oD0X0.
  - iDATA changing while the key is held has no effect after capture.
  - Reset mid-debounce or mid-press: all state returns to reset values. A key still held after reset release must first count as stable low before the write; no write occurs if it is released earlier.
- Slot outputs are direct register outputs; no combinational path from inputs.

Optional Feature:
- Macro: LCD_SLOT_CLEAR_EN.
- When defined:
  - Adds input iCLR_N (1 bit, active-low raw button), debounced identically by a second debounce instance.
  - Its press event clears all slots to 0 and sets oPTR to 0. oWR_STB stays 0.
  - If clear and write events occur in the same cycle, clear wins and the write is dropped.
- When undefined: port iCLR_N is absent and no clear logic exists.

Decomposition:
- Package lcd_slot_pkg holds:
  - NUM_SLOTS = 12
  - PTR_W = 4
  - SLOT_RESET = 0
  - LAST_SLOT = 11
  - the default DEBOUNCE_CYCLES constant
- Sub-module key_debounce:
  - Contents: 2-flop synchronizer, debounce counter and stable-level register, falling-edge press pulse output.
  - Parameterised by DEBOUNCE_CYCLES.
  - Instantiated once, or twice with LCD_SLOT_CLEAR_EN.

Test Plan (all with DEBOUNCE_CYCLES = 4):
- Reset, then hold iKEY_N = 1 for 50 cycles -> all slots 0, oPTR = 0, oWR_STB never high.
- iDATA = 8'h3A, iKEY_N low for 20 cycles -> oD0X0 = 8'h3A exactly 6 cycles after the first low sample; oPTR = 1; oWR_STB high for exactly one cycle; no second write while held.
- iKEY_N bounce pattern 0,1,0,1,0 with 1-cycle pulses, then stable low -> exactly one write; no write during the bounce.
- 13 clean presses with iDATA = 1..13 -> oD0X0 = 13, oD0X1..oD1X5 = 2..12, oPTR = 1.
- Assert iRST_N low at counter = 2 mid-debounce -> immediate reset values; the key held through reset release writes only after 4 stable cycles.
- With LCD_SLOT_CLEAR_EN: iKEY_N and iCLR_N pressed so both events land on the same cycle -> all slots 0, oPTR = 0, oWR_STB stays 0.

Source files
------------

// File: rtl/lcd_slot_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_slot_pkg
// Description : Shared constants and the write-pointer helper for the
//               LCD slot loader and its key debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_slot_pkg;

    localparam int NUM_SLOTS               = 12;
    localparam int PTR_W                   = 4;
    localparam int SLOT_RESET              = 0;
    localparam logic [PTR_W-1:0] LAST_SLOT = 4'd11;
    // 20 ms at 50 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;

    // Advance the write pointer, wrapping after the last slot
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_SLOT) ? '0 : ptr + 1'b1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// Module      : key_debounce
// Description : 2-flop synchronizer, stable-level debouncer and a one-cycle
//               press pulse for an active-low push button. The pulse is
//               asserted in the cycle whose closing edge moves the stable
//               level from released (1) to pressed (0).
// Revision    : 1.0 - initial release
// ============================================================================
module key_debounce
    import lcd_slot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_key_n,
    output logic o_press
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync0;
    logic             r_sync1;
    logic             r_stable;
    logic [CNT_W-1:0] r_cnt;
    logic             w_key_s;
    logic             w_accept;

    assign w_key_s  = r_sync1;
    // Level has differed for DEBOUNCE_CYCLES cycles: take it on this edge
    assign w_accept = (w_key_s != r_stable) && (r_cnt == CNT_LAST);
    assign o_press  = w_accept & ~w_key_s;

    // Two-stage synchronizer; resets to the released level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync0 <= 1'b1;
            r_sync1 <= 1'b1;
        end else begin
            r_sync0 <= i_key_n;
            r_sync1 <= r_sync0;
        end
    end

    // Count consecutive differing cycles; any bounce back restarts the count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stable <= 1'b1;
            r_cnt    <= '0;
        end else if (w_key_s == r_stable) begin
            r_cnt    <= '0;
        end else if (w_accept) begin
            r_stable <= w_key_s;
            r_cnt    <= '0;
        end else begin
            r_cnt    <= r_cnt + 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/lcd_slot_loader.sv
`default_nettype none
// ============================================================================
// Module      : lcd_slot_loader
// Description : Twelve-slot rolling display log for the LCD driver. Each
//               debounced press of iKEY_N stores iDATA in the next slot;
//               the pointer wraps from slot 11 back to slot 0.
//               Optional macro LCD_SLOT_CLEAR_EN adds a debounced iCLR_N
//               button that clears every slot and the pointer; a clear
//               landing with a write drops the write.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_slot_loader
    import lcd_slot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int SLOT_W          = 8
) (
    input  logic              iCLK,
    input  logic              iRST_N,
    input  logic              iKEY_N,
`ifdef LCD_SLOT_CLEAR_EN
    input  logic              iCLR_N,
`endif
    input  logic [SLOT_W-1:0] iDATA,
    output logic [SLOT_W-1:0] oD0X0,
    output logic [SLOT_W-1:0] oD0X1,
    output logic [SLOT_W-1:0] oD0X2,
    output logic [SLOT_W-1:0] oD0X3,
    output logic [SLOT_W-1:0] oD0X4,
    output logic [SLOT_W-1:0] oD0X5,
    output logic [SLOT_W-1:0] oD1X0,
    output logic [SLOT_W-1:0] oD1X1,
    output logic [SLOT_W-1:0] oD1X2,
    output logic [SLOT_W-1:0] oD1X3,
    output logic [SLOT_W-1:0] oD1X4,
    output logic [SLOT_W-1:0] oD1X5,
    output logic [3:0]        oPTR,
    output logic              oWR_STB
);

    logic [SLOT_W-1:0] r_slot [NUM_SLOTS];
    logic [PTR_W-1:0]  r_ptr;
    logic              r_wr_stb;
    logic              w_press;
    logic              w_clr;
    logic              w_write;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_db (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .i_key_n (iKEY_N),
        .o_press (w_press)
    );

`ifdef LCD_SLOT_CLEAR_EN
    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_clr_db (
        .clk     (iCLK),
        .rst_n   (iRST_N),
        .i_key_n (iCLR_N),
        .o_press (w_clr)
    );
`else
    assign w_clr = 1'b0;
`endif

    // Clear has priority over a simultaneous write
    assign w_write = w_press & ~w_clr;

    // Slot storage, write pointer and post-write strobe
    always_ff @(posedge iCLK or negedge iRST_N) begin
        if (!iRST_N) begin
            for (int i = 0; i < NUM_SLOTS; i++) begin
                r_slot[i] <= SLOT_W'(SLOT_RESET);
            end
            r_ptr    <= '0;
            r_wr_stb <= 1'b0;
        end else begin
            r_wr_stb <= w_write;
            if (w_clr) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    r_slot[i] <= SLOT_W'(SLOT_RESET);
                end
                r_ptr <= '0;
            end else if (w_press) begin
                for (int i = 0; i < NUM_SLOTS; i++) begin
                    if (r_ptr == PTR_W'(i)) begin
                        r_slot[i] <= iDATA;
                    end
                end
                r_ptr <= next_ptr(r_ptr);
            end
        end
    end

    assign oD0X0   = r_slot[0];
    assign oD0X1   = r_slot[1];
    assign oD0X2   = r_slot[2];
    assign oD0X3   = r_slot[3];
    assign oD0X4   = r_slot[4];
    assign oD0X5   = r_slot[5];
    assign oD1X0   = r_slot[6];
    assign oD1X1   = r_slot[7];
    assign oD1X2   = r_slot[8];
    assign oD1X3   = r_slot[9];
    assign oD1X4   = r_slot[10];
    assign oD1X5   = r_slot[11];
    assign oPTR    = r_ptr;
    assign oWR_STB = r_wr_stb;

endmodule
`default_nettype wire
